// File: rtl/fifo_sync_buf_cntrl.sv
// -----------------------------------------------------------------------------
// fifo_sync_buf_cntrl
//   Single-clock FIFO buffer for same-domain buffering between the register
//   file, ALU and UART paths. Holds storage plus pointer, occupancy and status
//   management, with programmable almost-full/almost-empty thresholds and
//   sticky overflow/underflow flags.
//
//   Build option:
//     FIFO_SYNC_FWFT_EN  defined   -> first-word-fall-through read port
//                                     (rdata shows the head word
//                                     combinationally, 0 when empty)
//                        undefined -> registered read port, 1-cycle latency
//
//   Ports:
//     wclk          clock, all logic on the rising edge
//     wrst          synchronous active-high reset
//     wclken        write request
//     wdata         write data
//     rclken        read request
//     clr_flags     clears sticky overflow/underflow (a new event wins)
//     rdata         read data
//     count         occupancy, 0..ADDRESS_DEPTH
//     full, empty   count == ADDRESS_DEPTH / count == 0
//     almost_full   count >= AFULL_THRESH
//     almost_empty  count <= AEMPTY_THRESH
//     overflow      sticky: write requested while full
//     underflow     sticky: read requested while empty
// -----------------------------------------------------------------------------
module fifo_sync_buf_cntrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3,
  parameter int ADDRESS_DEPTH = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic                     wclken,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     rclken,
  input  logic                     clr_flags,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_C  = (ADDRESS_WIDTH+1)'(ADDRESS_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] AFULL_C  = (ADDRESS_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDRESS_WIDTH:0] AEMPTY_C = (ADDRESS_WIDTH+1)'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0]  mem [ADDRESS_DEPTH];
  logic [ADDRESS_WIDTH:0] wptr_p0;
  logic [ADDRESS_WIDTH:0] rptr_p0;
  logic [ADDRESS_WIDTH:0] count_p0;
  logic                   ovf_p0;
  logic                   unf_p0;
  logic                   wa;
  logic                   ra;

  // Occupancy update: a simultaneous accept on both sides cancels out.
  function automatic logic [ADDRESS_WIDTH:0] next_count(
    input logic [ADDRESS_WIDTH:0] c,
    input logic                   w,
    input logic                   r
  );
    case ({w, r})
      2'b10:   next_count = c + 1'b1;
      2'b01:   next_count = c - 1'b1;
      default: next_count = c;
    endcase
  endfunction

  // Acceptance uses the registered flags, so a full FIFO refuses a write
  // even when a read frees a slot in the same cycle (no write-through), and
  // an empty FIFO refuses a read even when a write arrives alongside it.
  assign wa = wclken && !full;
  assign ra = rclken && !empty;

  // Stage p0: pointers, occupancy and sticky flags
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_p0  <= '0;
      rptr_p0  <= '0;
      count_p0 <= '0;
      ovf_p0   <= 1'b0;
      unf_p0   <= 1'b0;
    end else begin
      if (wa) wptr_p0 <= wptr_p0 + 1'b1;
      if (ra) rptr_p0 <= rptr_p0 + 1'b1;
      count_p0 <= next_count(count_p0, wa, ra);
      // A new event takes priority over a clear issued in the same cycle.
      if (wclken && full)  ovf_p0 <= 1'b1;
      else if (clr_flags)  ovf_p0 <= 1'b0;
      if (rclken && empty) unf_p0 <= 1'b1;
      else if (clr_flags)  unf_p0 <= 1'b0;
    end
  end

  // Storage is intentionally not reset; the pointers define what is valid.
  always_ff @(posedge wclk) begin
    if (wa) mem[wptr_p0[ADDRESS_WIDTH-1:0]] <= wdata;
  end

`ifdef FIFO_SYNC_FWFT_EN
  assign rdata = empty ? '0 : mem[rptr_p0[ADDRESS_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] rdata_p1;

  // Stage p1: registered read port, holds its value between accepted reads
  always_ff @(posedge wclk) begin
    if (wrst)    rdata_p1 <= '0;
    else if (ra) rdata_p1 <= mem[rptr_p0[ADDRESS_WIDTH-1:0]];
  end

  assign rdata = rdata_p1;
`endif

  assign count        = count_p0;
  assign full         = (count_p0 == DEPTH_C);
  assign empty        = (count_p0 == '0);
  assign almost_full  = (count_p0 >= AFULL_C);
  assign almost_empty = (count_p0 <= AEMPTY_C);
  assign overflow     = ovf_p0;
  assign underflow    = unf_p0;

endmodule

// File: tb/tb_fifo_sync_buf_cntrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_buf_cntrl
//   Directed self-checking bench for fifo_sync_buf_cntrl (default 8x8 build).
//   Inputs change 1 time unit after the rising edge; outputs are checked at
//   that same point, once the edge's updates have settled. A queue holds the
//   expected read order. Builds with or without FIFO_SYNC_FWFT_EN.
// -----------------------------------------------------------------------------
module tb_fifo_sync_buf_cntrl;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       wclken;
  logic [7:0] wdata;
  logic       rclken;
  logic       clr_flags;
  logic [7:0] rdata;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  sb[$];
  logic [7:0]  exp_d;

  fifo_sync_buf_cntrl #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(3), .ADDRESS_DEPTH(8),
    .AFULL_THRESH(6), .AEMPTY_THRESH(2)
  ) dut (
    .wclk(wclk), .wrst(wrst), .wclken(wclken), .wdata(wdata),
    .rclken(rclken), .clr_flags(clr_flags), .rdata(rdata), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic idle();
    wclken = 1'b0; rclken = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wclken = 1'b1; wdata = d; rclken = 1'b0;
    sb.push_back(d);
    step();
    idle();
  endtask

  // One read; the expected word comes from the scoreboard. In FWFT mode the
  // head word is visible before the read, otherwise one edge after it.
  task automatic pop(input string tag);
    exp_d = sb.pop_front();
    wclken = 1'b0; rclken = 1'b1;
`ifdef FIFO_SYNC_FWFT_EN
    chk(tag, rdata, exp_d);
    step();
`else
    step();
    chk(tag, rdata, exp_d);
`endif
    idle();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_aempty"}, almost_empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, almost_full, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_unf"}, underflow, 0);
  endtask

  initial begin
    idle();
    wdata = 8'h00;
    wrst  = 1'b1;

    // Reset with random request activity
    for (int i = 0; i < 2; i++) begin
      wclken = 1'($urandom_range(1));
      rclken = 1'($urandom_range(1));
      wdata  = 8'($urandom);
      step();
    end
    idle();
    wrst = 1'b0;
    chk_reset_state("rst");

    // Fill with 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      push(8'((i + 1) * 8'h11));
      chk($sformatf("fill_count%0d", i), count, i + 1);
      chk($sformatf("fill_afull%0d", i), almost_full, (i + 1) >= 6);
      chk($sformatf("fill_full%0d", i), full, (i + 1) == 8);
    end

    // Write while full: refused, overflow sticks
    wclken = 1'b1; wdata = 8'h99;
    step();
    idle();
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    chk("ovf_full", full, 1);

    // Drain: 0x11..0x88 in order, 0x99 never appears
    for (int i = 0; i < 8; i++) begin
      pop($sformatf("drain_data%0d", i));
      chk($sformatf("drain_count%0d", i), count, 7 - i);
      chk($sformatf("drain_aempty%0d", i), almost_empty, (7 - i) <= 2);
    end
    chk("drain_empty", empty, 1);

    // Read while empty: refused, underflow sticks, rdata unaffected
    rclken = 1'b1;
    step();
    idle();
    chk("unf_set", underflow, 1);
    chk("unf_count", count, 0);
`ifdef FIFO_SYNC_FWFT_EN
    chk("unf_rdata", rdata, 8'h00);
`else
    chk("unf_rdata_hold", rdata, 8'h88);
`endif

    // Clear together with a fresh empty read: set wins for underflow,
    // overflow (no new event) clears
    rclken = 1'b1; clr_flags = 1'b1;
    step();
    idle();
    chk("clr_unf_setwins", underflow, 1);
    chk("clr_ovf_cleared", overflow, 0);
    clr_flags = 1'b1;
    step();
    idle();
    chk("clr_unf_alone", underflow, 0);

    // Four words, then ten simultaneous read/write cycles
    for (int i = 0; i < 4; i++) push(8'(8'h01 + i));
    chk("sim_count_pre", count, 4);
    for (int k = 0; k < 10; k++) begin
      exp_d = sb.pop_front();
      wclken = 1'b1; rclken = 1'b1; wdata = 8'(8'h05 + k);
      sb.push_back(wdata);
`ifdef FIFO_SYNC_FWFT_EN
      chk($sformatf("sim_data%0d", k), rdata, exp_d);
      step();
`else
      step();
      chk($sformatf("sim_data%0d", k), rdata, exp_d);
`endif
      idle();
      chk($sformatf("sim_count%0d", k), count, 4);
    end

    // Fill to full, then read+write together: read only
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    chk("full_again", full, 1);
    exp_d = sb.pop_front();
    wclken = 1'b1; rclken = 1'b1; wdata = 8'hEE;
`ifdef FIFO_SYNC_FWFT_EN
    chk("fullrw_data", rdata, exp_d);
    step();
`else
    step();
    chk("fullrw_data", rdata, exp_d);
`endif
    idle();
    chk("fullrw_count", count, 7);
    chk("fullrw_ovf", overflow, 1);

    // Drain to 2 (0xEE must not appear), then 20 write/read pairs with the
    // occupancy kept between 2 and 3 so both pointers wrap
    for (int i = 0; i < 5; i++) pop($sformatf("wrapdrain%0d", i));
    chk("wrap_count_pre", count, 2);
    for (int k = 0; k < 20; k++) begin
      push(8'(8'h30 + k));
      pop($sformatf("wrap_data%0d", k));
    end
    chk("wrap_count_post", count, 2);

    // Mid-operation reset discards contents; first word after lands cleanly
    wrst = 1'b1; clr_flags = 1'b0;
    step();
    wrst = 1'b0;
    sb.delete();
    chk_reset_state("rst2");
    push(8'hA5);
    chk("post_rst_count", count, 1);
    chk("post_rst_empty", empty, 0);
`ifdef FIFO_SYNC_FWFT_EN
    chk("fwft_head", rdata, 8'hA5);
    rclken = 1'b1;
    step();
    idle();
    void'(sb.pop_front());
    chk("fwft_empty", empty, 1);
    chk("fwft_rdata0", rdata, 8'h00);
`else
    pop("post_rst_data");
    chk("post_rst_empty2", empty, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
